booth_mul_seq: RTL

- Sequential radix-2 Booth signed multiplier for the 8-bit ALU.
- It is the stage directly upstream of the 17-bit arithmetic shifter. It owns the {A, Q, Q-1} product register, performs the add/subtract of the multiplicand each iteration, and feeds the result through a shifter instance in right-shift mode.
- Produces a 2*WIDTH-bit signed product after WIDTH iterations, with a start/busy/done handshake toward the ALU control.

---
 rtl/booth_mul_seq_pkg.sv | 19 +
 rtl/booth_mul_seq_if.sv | 30 +++
 rtl/booth_mul_seq_shifter.sv | 26 ++
 rtl/booth_mul_seq.sv | 139 +++++++++++++
 4 files changed

// File: rtl/booth_mul_seq_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : booth_mul_seq_pkg                                  |
// | Description : Shared constants for the sequential Booth          |
// |               multiplier (FSM encoding, Booth recoding codes).   |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
package booth_mul_seq_pkg;

  // FSM state encoding
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Booth codes on {Q0, Q-1}; 00 and 11 leave A unchanged
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage : booth_mul_seq_pkg
`default_nettype wire

// File: rtl/booth_mul_seq_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : booth_mul_seq_if                                   |
// | Description : start/busy/done handshake and operand/result bus   |
// |               between ALU control (master) and the multiplier.   |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
interface booth_mul_seq_if #(
  parameter int WIDTH = 8
);

  logic                   start;
  logic [WIDTH-1:0]       multiplicand;
  logic [WIDTH-1:0]       multiplier;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH-1:0]     product;

  modport master (
    output start, multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output busy, done, product
  );

endinterface : booth_mul_seq_if
`default_nettype wire

// File: rtl/booth_mul_seq_shifter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : booth_mul_seq_shifter                              |
// | Description : Single-bit arithmetic shifter. dir_i=0 shifts      |
// |               right with sign fill, dir_i=1 shifts left.         |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module booth_mul_seq_shifter #(
  parameter int WIDTH = 17
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             dir_i,
  output logic [WIDTH-1:0] data_o
);

  // One-position shift; right shifts replicate the sign bit
  always_comb begin
    if (dir_i) begin
      data_o = {data_i[WIDTH-2:0], 1'b0};
    end else begin
      data_o = {data_i[WIDTH-1], data_i[WIDTH-1:1]};
    end
  end

endmodule : booth_mul_seq_shifter
`default_nettype wire

// File: rtl/booth_mul_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : booth_mul_seq                                      |
// | Description : Sequential radix-2 Booth signed multiplier. Owns   |
// |               the {A, Q, Q-1} register, does the per-iteration   |
// |               add/subtract with a guard bit and shifts through   |
// |               the arithmetic shifter. WIDTH clocks per product.  |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module booth_mul_seq
  import booth_mul_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  booth_mul_seq_if.slave    bus
);

  localparam int PW = 2*WIDTH + 1;

  logic [0:0]         state_q, state_d;
  logic [PW-1:0]      p_q, p_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               done_q, done_d;

  logic [WIDTH:0]     a_ext;
  logic [WIDTH:0]     m_ext;
  logic [WIDTH:0]     g;
  logic [PW-1:0]      shift_in;
  logic [PW-1:0]      shift_out;
  logic [PW-1:0]      p_run;
  logic               last_iter;
  logic               accept;
  logic               busy;

  // A and M are widened by one bit so -2**(W-1) subtracts without overflow
  assign a_ext     = {p_q[PW-1], p_q[PW-1:WIDTH+1]};
  assign m_ext     = {m_q[WIDTH-1], m_q};
  assign last_iter = (count_q == CNT_W'(WIDTH-1));
  assign accept    = (state_q == ST_IDLE) && bus.start;

  // Booth recoding: add, subtract or pass A based on {Q0, Q-1}
  always_comb begin
    g = a_ext;
    unique case (p_q[1:0])
      BOOTH_ADD: g = a_ext + m_ext;
      BOOTH_SUB: g = a_ext - m_ext;
      default:   g = a_ext;
    endcase
  end

  assign shift_in = {g[WIDTH-1:0], p_q[WIDTH:0]};

  booth_mul_seq_shifter #(
    .WIDTH (PW)
  ) u_shifter (
    .data_i (shift_in),
    .dir_i  (1'b0),
    .data_o (shift_out)
  );

  // Shifter fills with G[W-1]; the true sign is the guard bit G[W]
  always_comb begin
    p_run       = shift_out;
    p_run[PW-1] = g[WIDTH];
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: accept start only in IDLE, leave RUN after WIDTH steps
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_RUN;
      ST_RUN:  if (last_iter) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q == ST_RUN);
  end

  // Datapath next values: operand capture, iteration, result latch
  always_comb begin
    p_d       = p_q;
    m_d       = m_q;
    count_d   = count_q;
    product_d = product_q;
    done_d    = 1'b0;
    if (accept) begin
      m_d     = bus.multiplicand;
      p_d     = {{WIDTH{1'b0}}, bus.multiplier, 1'b0};
      count_d = '0;
    end else if (state_q == ST_RUN) begin
      p_d     = p_run;
      count_d = count_q + 1'b1;
      if (last_iter) begin
        product_d = p_run[PW-1:1];
        done_d    = 1'b1;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q       <= '0;
      m_q       <= '0;
      count_q   <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      p_q       <= p_d;
      m_q       <= m_d;
      count_q   <= count_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy    = busy;
  assign bus.done    = done_q;
  assign bus.product = product_q;

endmodule : booth_mul_seq
`default_nettype wire
